// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types and encodings for the long-latency integer divide pipe
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg     = 1'b0,
    e_bp_multicore_1_cfg = 1'b1
  } bp_params_e;

  localparam int dpath_width_gp    = 64;
  localparam int instr_width_gp    = 32;
  localparam int reg_addr_width_gp = 5;

  // Every shipped configuration carries a 64-bit integer datapath.
  function automatic int proc_dword_width(bp_params_e cfg);
    case (cfg)
      e_bp_multicore_1_cfg: return 64;
      default:              return 64;
    endcase
  endfunction

  typedef enum logic [3:0] {
    e_int_op_div  = 4'b0100,
    e_int_op_divu = 4'b0101,
    e_int_op_rem  = 4'b0110,
    e_int_op_remu = 4'b0111
  } bp_be_int_fu_op_e;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_busy  = 2'd1,
    e_fixup = 2'd2,
    e_done  = 2'd3
  } bp_be_idiv_state_e;

  typedef struct packed {
    logic             pipe_long_v;
    logic             opw_v;
    bp_be_int_fu_op_e fu_op;
  } bp_be_decode_s;

  typedef struct packed {
    logic                      v;
    logic                      poison;
    bp_be_decode_s             decode;
    logic [dpath_width_gp-1:0] rs1;
    logic [dpath_width_gp-1:0] rs2;
    logic [instr_width_gp-1:0] instr;
  } bp_be_dispatch_pkt_s;

  typedef struct packed {
    bp_be_int_fu_op_e             op;
    logic                         opw;
    logic                         q_neg;
    logic                         r_neg;
    logic [reg_addr_width_gp-1:0] rd_addr;
  } bp_be_idiv_op_s;

endpackage

// File: rtl/bp_be_pipe_idiv_if.sv
// rtl/bp_be_pipe_idiv_if.sv - dispatch/result handshake bundle for the divide pipe
interface bp_be_pipe_idiv_if;
  import bp_be_pkg::*;

  logic                         ready_o;
  bp_be_dispatch_pkt_s          reservation_i;
  logic                         flush_i;
  logic [dpath_width_gp-1:0]    data_o;
  logic [reg_addr_width_gp-1:0] rd_addr_o;
  logic                         v_o;
  logic                         yumi_i;

  modport slave (
    output ready_o, data_o, rd_addr_o, v_o,
    input  reservation_i, flush_i, yumi_i
  );

  modport master (
    input  ready_o, data_o, rd_addr_o, v_o,
    output reservation_i, flush_i, yumi_i
  );

endinterface

// File: rtl/bp_be_idiv_iter.sv
// rtl/bp_be_idiv_iter.sv - restoring shift-subtract divider core, one quotient bit per step
module bp_be_idiv_iter #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o
);

  logic [width_p-1:0] rem_q, rem_d;
  logic [width_p-1:0] quo_q, quo_d;
  logic [width_p-1:0] div_q, div_d;
  logic [width_p:0]   partial;
  logic [width_p:0]   diff;
  logic               ge;

  // quo_q starts as the dividend and is shifted out MSB-first while quotient bits shift in.
  // A zero divisor always takes the subtract path, which yields all-ones and rem = dividend.
  always_comb begin
    partial = {rem_q, quo_q[width_p-1]};
    diff    = partial - {1'b0, div_q};
    ge      = (partial >= {1'b0, div_q});
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      div_d = divisor_i;
    end else if (step_i) begin
      rem_d = ge ? diff[width_p-1:0] : partial[width_p-1:0];
      quo_d = {quo_q[width_p-2:0], ge};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/bp_be_pipe_idiv.sv
// rtl/bp_be_pipe_idiv.sv - iterative integer divide/remainder pipe: FSM, sign handling, handshakes
module bp_be_pipe_idiv
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         width_p     = proc_dword_width(bp_params_p)
) (
  input logic              clk_i,
  input logic              reset_i,
  bp_be_pipe_idiv_if.slave io
);

  localparam int dpath_width_lp = proc_dword_width(bp_params_p);
  localparam int cnt_width_lp   = $clog2(width_p);
  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(width_p - 1);

  bp_be_idiv_state_e       state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  bp_be_idiv_op_s          op_q, op_d, new_op;
  logic [width_p-1:0]      result_q, result_d;

  bp_be_dispatch_pkt_s pkt;
  logic               fire, is_signed, a_neg, b_neg, b_zero, load, step;
  logic [width_p-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [width_p-1:0] quo_mag, rem_mag, quo_fix, rem_fix, res_fix;
  logic               unused_pkt;

  assign pkt        = io.reservation_i;
  assign unused_pkt = ^{pkt.instr[31:12], pkt.instr[6:0]};
  assign io.ready_o = (state_q == e_idle);
  assign fire       = io.ready_o & pkt.v & ~pkt.poison & pkt.decode.pipe_long_v & ~io.flush_i;
  assign is_signed  = (pkt.decode.fu_op == e_int_op_div) | (pkt.decode.fu_op == e_int_op_rem);

  // Word ops extend the low half per signedness so the core only ever sees width_p magnitudes.
  always_comb begin
    a_ext = pkt.rs1[width_p-1:0];
    b_ext = pkt.rs2[width_p-1:0];
    if (pkt.decode.opw_v) begin
      for (int i = 32; i < width_p; i++) begin
        a_ext[i] = is_signed & pkt.rs1[31];
        b_ext[i] = is_signed & pkt.rs2[31];
      end
    end
    a_neg  = is_signed & a_ext[width_p-1];
    b_neg  = is_signed & b_ext[width_p-1];
    b_zero = (b_ext == '0);
    a_mag  = a_neg ? -a_ext : a_ext;
    b_mag  = b_neg ? -b_ext : b_ext;
    new_op.op      = pkt.decode.fu_op;
    new_op.opw     = pkt.decode.opw_v;
    new_op.q_neg   = (a_neg ^ b_neg) & ~b_zero;
    new_op.r_neg   = a_neg;
    new_op.rd_addr = pkt.instr[11:7];
  end

  bp_be_idiv_iter #(.width_p(width_p)) iter (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .load_i      (load),
    .step_i      (step),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (quo_mag),
    .remainder_o (rem_mag)
  );

  always_comb begin
    quo_fix = op_q.q_neg ? -quo_mag : quo_mag;
    rem_fix = op_q.r_neg ? -rem_mag : rem_mag;
    res_fix = ((op_q.op == e_int_op_rem) | (op_q.op == e_int_op_remu)) ? rem_fix : quo_fix;
    if (op_q.opw) begin
      for (int i = 32; i < width_p; i++) begin
        res_fix[i] = res_fix[31];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (fire) begin
          state_d = e_busy;
          cnt_d   = '0;
          load    = 1'b1;
          op_d    = new_op;
        end
      end
      e_busy: begin
        step = 1'b1;
        if (cnt_q == cnt_last_lp) state_d = e_fixup;
        else                      cnt_d   = cnt_q + cnt_width_lp'(1);
      end
      e_fixup: begin
        state_d  = e_done;
        result_d = res_fix;
      end
      e_done: begin
        if (io.yumi_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
    // Flush beats yumi and any pending result update.
    if (io.flush_i) begin
      state_d  = e_idle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign io.v_o       = (state_q == e_done);
  assign io.data_o    = dpath_width_lp'(result_q);
  assign io.rd_addr_o = op_q.rd_addr;

endmodule

// File: tb/tb_bp_be_pipe_idiv.sv
// tb/tb_bp_be_pipe_idiv.sv - scoreboard bench for the integer divide pipe
module tb_bp_be_pipe_idiv;
  import bp_be_pkg::*;

  localparam int W = 64;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    int          fire_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  logic v_prev = 1'b0;
  bp_be_int_fu_op_e ops[4] = '{e_int_op_div, e_int_op_divu, e_int_op_rem, e_int_op_remu};

  bp_be_pipe_idiv_if dif ();

  bp_be_pipe_idiv #(.bp_params_p(e_bp_default_cfg), .width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M-extension semantics, evaluated directly with integer arithmetic.
  function automatic logic [63:0] ref_model(bp_be_int_fu_op_e op, bit opw, logic [63:0] a, logic [63:0] b);
    int sa32, sb32;
    int unsigned ua32, ub32;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [31:0] r32;
    logic [63:0] r;
    bit is_div, is_sgn;
    is_div = (op == e_int_op_div) || (op == e_int_op_divu);
    is_sgn = (op == e_int_op_div) || (op == e_int_op_rem);
    if (opw) begin
      sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      if (ub32 == 0) r32 = is_div ? 32'hFFFF_FFFF : a[31:0];
      else if (is_sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = is_div ? 32'h8000_0000 : 32'h0;
      else case (op)
        e_int_op_div:  r32 = sa32 / sb32;
        e_int_op_divu: r32 = ua32 / ub32;
        e_int_op_rem:  r32 = sa32 % sb32;
        default:       r32 = ua32 % ub32;
      endcase
      return {{32{r32[31]}}, r32};
    end
    sa = a; sb = b; ua = a; ub = b;
    if (ub == 0) r = is_div ? 64'hFFFF_FFFF_FFFF_FFFF : a;
    else if (is_sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      r = is_div ? a : 64'h0;
    else case (op)
      e_int_op_div:  r = sa / sb;
      e_int_op_divu: r = ua / ub;
      e_int_op_rem:  r = sa % sb;
      default:       r = ua % ub;
    endcase
    return r;
  endfunction

  task automatic drive_junk();
    bp_be_dispatch_pkt_s p;
    int k;
    k = $urandom_range(0, 2);
    p.v                  = 1'($urandom_range(0, 1));
    p.poison             = (k != 1);
    p.decode.pipe_long_v = (k == 0);
    p.decode.opw_v       = 1'($urandom_range(0, 1));
    p.decode.fu_op       = ops[$urandom_range(0, 3)];
    p.rs1                = {$urandom, $urandom};
    p.rs2                = {$urandom, $urandom};
    p.instr              = $urandom;
    dif.reservation_i = p;
  endtask

  task automatic drive_op(input bp_be_int_fu_op_e op, input bit opw, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
    bp_be_dispatch_pkt_s p;
    p.v = 1'b1; p.poison = 1'b0;
    p.decode.pipe_long_v = 1'b1; p.decode.opw_v = opw; p.decode.fu_op = op;
    p.rs1 = a; p.rs2 = b;
    p.instr = {20'($urandom), rd, 7'h33};
    dif.reservation_i = p;
  endtask

  task automatic issue(input bp_be_int_fu_op_e op, input bit opw, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input bit expect_result);
    int n = 0;
    exp_t e;
    while (dif.ready_o !== 1'b1 && n < 200) begin
      drive_junk(); @(negedge clk); n++;
    end
    chk("issue_ready", dif.ready_o, 1);
    drive_op(op, opw, a, b, rd);
    if (expect_result) begin
      e.data = ref_model(op, opw, a, b); e.rd = rd; e.fire_cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    drive_junk();
    chk("busy_not_ready", dif.ready_o, 0);
  endtask

  task automatic finish_op(input int hold, input bit flush_end);
    int n = 0;
    while (dif.v_o !== 1'b1 && n < 200) begin
      @(negedge clk); drive_junk(); n++;
    end
    chk("result_timeout", dif.v_o, 1);
    repeat (hold) begin @(negedge clk); drive_junk(); end
    dif.yumi_i = 1'b1; dif.flush_i = flush_end;
    @(negedge clk);
    dif.yumi_i = 1'b0; dif.flush_i = 1'b0; drive_junk();
    chk("ready_after_yumi", dif.ready_o, 1);
    chk("v_after_yumi", dif.v_o, 0);
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 64'($urandom_range(0, 20));
      1: return -64'($urandom_range(1, 20));
      2: return 64'h0;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_FFFF_FFFF;
      5: return {$urandom, 32'h8000_0000 | 32'($urandom_range(0, 3))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Scoreboard monitor: pops on each rising v_o, then holds the result under watch until it drops.
  always @(negedge clk) begin
    if (dif.v_o === 1'b1) begin
      if (v_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_v", dif.v_o, 0);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("data", dif.data_o, cur.data);
          chk("rd_addr", 64'(dif.rd_addr_o), 64'(cur.rd));
          chk("latency", 64'(cyc - cur.fire_cyc), 64'(W + 2));
        end
      end else if (have_cur) begin
        chk("data_stable", dif.data_o, cur.data);
        chk("rd_stable", 64'(dif.rd_addr_o), 64'(cur.rd));
      end
    end
    v_prev = dif.v_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.flush_i = 1'b0;
    dif.yumi_i  = 1'b0;
    drive_junk();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", dif.ready_o, 1);
    chk("reset_v", dif.v_o, 0);
    chk("reset_data", dif.data_o, 0);
    chk("reset_rd", 64'(dif.rd_addr_o), 0);

    issue(e_int_op_divu, 1'b0, 64'd100, 64'd7, 5'd3, 1'b1); finish_op(0, 1'b0);
    issue(e_int_op_remu, 1'b0, 64'd100, 64'd7, 5'd4, 1'b1); finish_op(0, 1'b0);
    issue(e_int_op_div,  1'b0, -64'd7, 64'd2, 5'd5, 1'b1);  finish_op(1, 1'b0);
    issue(e_int_op_rem,  1'b0, -64'd7, 64'd2, 5'd6, 1'b1);  finish_op(0, 1'b0);
    issue(e_int_op_div,  1'b1, 64'h1_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b1); finish_op(0, 1'b0);
    issue(e_int_op_div,  1'b0, 64'd5, 64'd0, 5'd8, 1'b1);   finish_op(0, 1'b0);
    issue(e_int_op_remu, 1'b0, 64'd5, 64'd0, 5'd9, 1'b1);   finish_op(0, 1'b0);
    issue(e_int_op_div,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 1'b1); finish_op(0, 1'b0);
    issue(e_int_op_rem,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 1'b1); finish_op(5, 1'b0);

    // Flush ten cycles after fire: the op must vanish.
    issue(e_int_op_divu, 1'b0, 64'd1000, 64'd3, 5'd12, 1'b0);
    repeat (9) begin @(negedge clk); drive_junk(); end
    dif.flush_i = 1'b1;
    @(negedge clk);
    dif.flush_i = 1'b0;
    chk("flush_ready", dif.ready_o, 1);
    chk("flush_v", dif.v_o, 0);
    repeat (80) begin @(negedge clk); drive_junk(); end
    issue(e_int_op_rem, 1'b0, 64'd1000, -64'd3, 5'd13, 1'b1); finish_op(0, 1'b0);

    // A legal op presented alongside flush must not be accepted.
    drive_op(e_int_op_div, 1'b0, 64'd9, 64'd2, 5'd14);
    dif.flush_i = 1'b1;
    @(negedge clk);
    dif.flush_i = 1'b0; drive_junk();
    chk("flush_blocks_fire", dif.ready_o, 1);

    // Flush together with yumi behaves as a flush.
    issue(e_int_op_divw_sel(), 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h0000_0001_0000_0002, 5'd15, 1'b1);
    finish_op(2, 1'b1);

    // Reset twenty cycles after fire abandons the op.
    issue(e_int_op_divu, 1'b0, 64'd77, 64'd5, 5'd16, 1'b0);
    repeat (19) begin @(negedge clk); drive_junk(); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_v", dif.v_o, 0);
    chk("midreset_ready", dif.ready_o, 1);
    chk("midreset_data", dif.data_o, 0);
    repeat (80) begin @(negedge clk); drive_junk(); end
    issue(e_int_op_remu, 1'b0, 64'd77, 64'd5, 5'd17, 1'b1); finish_op(0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      issue(ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
            5'($urandom_range(0, 31)), 1'b1);
      finish_op($urandom_range(0, 3), 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic bp_be_int_fu_op_e e_int_op_divw_sel();
    return e_int_op_div;
  endfunction

endmodule
